// File: rtl/trigger_pkg.sv
// Shared types, default parameters and helpers for the coincidence trigger.
package trigger_pkg;

  localparam int unsigned DEF_WIDTH     = 12;
  localparam int unsigned DEF_N_CH      = 4;
  localparam int unsigned DEF_DT_WIDTH  = 30;
  localparam int unsigned DEF_WIN_WIDTH = 8;

  // Upper bound on channel count and the width needed to count up to it.
  localparam int unsigned MAX_CH = 16;
  localparam int unsigned POP_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    DEAD = 1'b1
  } state_t;

  // Number of set bits in a channel vector.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_CH); i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/trigger_coinc_channel.sv
// One trigger channel: rising threshold crossing detector and coincidence window.
// Optional feature macro: TRIG_HYSTERESIS_EN (adds hyst input and re-arm logic).
module trigger_channel
  import trigger_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned WIN_WIDTH = DEF_WIN_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic signed [WIDTH-1:0] threshold,
`ifdef TRIG_HYSTERESIS_EN
  input  logic [WIDTH-1:0]        hyst,
`endif
  input  logic [WIN_WIDTH-1:0]    coinc_window,
  input  logic                    win_en,
  input  logic                    win_clr,
  output logic                    ch_hit,
  output logic                    active_c
);

  logic signed [WIDTH-1:0] prev;
  logic                    prev_valid;
  logic [WIN_WIDTH-1:0]    win_cnt;
  logic                    cross_c;
  logic                    hit_c;

  assign cross_c = prev_valid && (prev < threshold) && (data_in >= threshold);

`ifdef TRIG_HYSTERESIS_EN
  logic                    armed;
  logic signed [WIDTH+1:0] thr_x;
  logic signed [WIDTH+1:0] hyst_x;
  logic signed [WIDTH+1:0] data_x;
  logic                    below_c;

  // Re-arm level computed with headroom so no threshold/hyst pair can wrap.
  assign thr_x   = (WIDTH+2)'(threshold);
  assign hyst_x  = signed'((WIDTH+2)'(hyst));
  assign data_x  = (WIDTH+2)'(data_in);
  assign below_c = data_x < (thr_x - hyst_x);
  assign hit_c   = cross_c && armed;

  // Armed flag: cleared by an accepted crossing, restored once well below threshold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      armed <= 1'b1;
    end else if (hit_c) begin
      armed <= 1'b0;
    end else if (below_c) begin
      armed <= 1'b1;
    end
  end
`else
  assign hit_c = cross_c;
`endif

  // Previous-sample history and the registered one-cycle hit flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      ch_hit     <= 1'b0;
    end else begin
      prev       <= data_in;
      prev_valid <= 1'b1;
      ch_hit     <= hit_c;
    end
  end

  // Coincidence window: reload on a hit while idle, flush when a trigger fires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_cnt <= '0;
    end else if (win_clr) begin
      win_cnt <= '0;
    end else if (ch_hit && win_en) begin
      win_cnt <= coinc_window;
    end else if (win_cnt != '0) begin
      win_cnt <= win_cnt - WIN_WIDTH'(1);
    end
  end

  assign active_c = ch_hit || (win_cnt != '0);

endmodule

// File: rtl/trigger_coinc.sv
// N-channel threshold trigger with coincidence window, majority logic and dead time.
// Optional feature macro: TRIG_HYSTERESIS_EN (per-channel hysteresis re-arm).
module trigger_coinc
  import trigger_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned DT_WIDTH  = DEF_DT_WIDTH,
  parameter int unsigned WIN_WIDTH = DEF_WIN_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH*WIDTH-1:0]      data_in,
  input  logic [N_CH*WIDTH-1:0]      threshold,
`ifdef TRIG_HYSTERESIS_EN
  input  logic [WIDTH-1:0]           hyst,
`endif
  input  logic [N_CH-1:0]            ch_mask,
  input  logic [$clog2(N_CH+1)-1:0]  majority,
  input  logic [WIN_WIDTH-1:0]       coinc_window,
  input  logic [DT_WIDTH-1:0]        disable_time,
  output logic [N_CH-1:0]            ch_hit,
  output logic                       pulse_out,
  output logic [31:0]                trig_count
);

  state_t              state;
  logic [DT_WIDTH-1:0] dt_cnt;
  logic [N_CH-1:0]     active_c;
  logic [POP_W-1:0]    n_act_c;
  logic                fire_c;

  // Per-channel crossing detectors.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    trigger_channel #(
      .WIDTH     (WIDTH),
      .WIN_WIDTH (WIN_WIDTH)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in[i*WIDTH +: WIDTH]),
      .threshold    (threshold[i*WIDTH +: WIDTH]),
`ifdef TRIG_HYSTERESIS_EN
      .hyst         (hyst),
`endif
      .coinc_window (coinc_window),
      .win_en       (state == IDLE),
      .win_clr      (fire_c),
      .ch_hit       (ch_hit[i]),
      .active_c     (active_c[i])
    );
  end

  // Majority decision over the masked active channels.
  assign n_act_c = popcount(MAX_CH'(active_c & ch_mask));
  assign fire_c  = (state == IDLE) && (majority != '0) && (n_act_c >= POP_W'(majority));

  // Trigger FSM: pulse and dead time share one counter; disable_time latched at fire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pulse_out  <= 1'b0;
      dt_cnt     <= '0;
      trig_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_c) begin
            state     <= DEAD;
            pulse_out <= 1'b1;
            dt_cnt    <= (disable_time == '0) ? DT_WIDTH'(1) : disable_time;
            if (trig_count != '1) begin
              trig_count <= trig_count + 32'd1;
            end
          end
        end
        DEAD: begin
          if (dt_cnt <= DT_WIDTH'(1)) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
            dt_cnt    <= '0;
          end else begin
            dt_cnt <= dt_cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          state     <= IDLE;
          pulse_out <= 1'b0;
          dt_cnt    <= '0;
        end
      endcase
    end
  end

endmodule
